// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: FIFO head, pop request, fill level and error flags.
// The receiver uses the master modport and the keyboard decode logic uses the slave modport.
interface ps2_rx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 3
);
  logic                  nextdata_n;
  logic                  clr_err;
  logic [7:0]            data;
  logic                  ready;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  parity_err;
  logic                  frame_err;

  modport master (
    input  nextdata_n, clr_err,
    output data, ready, level, overflow, parity_err, frame_err
  );

  modport slave (
    output nextdata_n, clr_err,
    input  data, ready, level, overflow, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchroniser, ps2_clk deglitch filter, frame FSM with
// parity/stop/timeout checks, and a scan-code FIFO with full/empty tracking by fill level.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_fifo_if.master bus
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam int unsigned LevelW = DEPTH_LOG2 + 1;
  localparam int unsigned FiltW  = $clog2(FILTER_LEN);
  localparam int unsigned ToW    = $clog2(TIMEOUT_CYC);

  localparam logic [FiltW-1:0]      FiltMax   = FiltW'(FILTER_LEN - 1);
  localparam logic [ToW-1:0]        ToMax     = ToW'(TIMEOUT_CYC - 1);
  localparam logic [LevelW-1:0]     LevelFull = LevelW'(Depth);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchroniser and deglitch filter
  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             ck_s, bit_s;
  logic             filt_q, filt_d;
  logic [FiltW-1:0] fcnt_q, fcnt_d;
  logic             strobe_q, strobe_d;

  assign ck_s  = clk_sync_q[1];
  assign bit_s = dat_sync_q[1];

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (ck_s != filt_q) begin
      if (fcnt_q == FiltMax) begin
        filt_d = ck_s;
      end else begin
        fcnt_d = fcnt_q + FiltW'(1);
      end
    end
    strobe_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      strobe_q   <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      strobe_q   <= strobe_d;
    end
  end

  // Frame FSM
  state_e         state_q, state_d;
  logic           timeout;
  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic           par_ok_q, par_ok_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           push_q, push_d;
  logic           perr_set, ferr_set;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A strobe in the same cycle as the timeout limit wins: it restarts the idle count.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    if (strobe_q) begin
      case (state_q)
        StIdle:   if (!bit_s) state_d = StData;
        StData:   if (bitcnt_q == 3'd7) state_d = StParity;
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end else if (state_q != StIdle && to_cnt_q == ToMax) begin
      timeout = 1'b1;
      state_d = StIdle;
    end
  end

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    par_ok_d = par_ok_q;
    push_d   = 1'b0;
    perr_set = 1'b0;
    ferr_set = timeout;
    to_cnt_d = (state_q == StIdle || strobe_q || timeout) ? '0 : to_cnt_q + ToW'(1);
    if (strobe_q) begin
      case (state_q)
        StIdle:   bitcnt_d = '0;
        StData: begin
          shreg_d  = {bit_s, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
        end
        StParity: par_ok_d = ^{shreg_q, bit_s};
        StStop: begin
          if (!bit_s) begin
            ferr_set = 1'b1;
          end else if (!par_ok_q) begin
            perr_set = 1'b1;
          end else begin
            push_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      par_ok_q <= 1'b0;
      to_cnt_q <= '0;
      push_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      par_ok_q <= par_ok_d;
      to_cnt_q <= to_cnt_d;
      push_q   <= push_d;
    end
  end

  // Scan-code FIFO
  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0]     level_q, level_d;
  logic                  ready, pop, full, wr_en, ovf_set;
  logic                  ovf_q, perr_q, ferr_q;

  assign ready   = (level_q != '0);
  assign pop     = ready & ~bus.nextdata_n;
  assign full    = (level_q == LevelFull);
  // When full, a simultaneous pop frees the slot the push is about to take.
  assign wr_en   = push_q & (~full | pop);
  assign ovf_set = push_q & full & ~pop;

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      level_q <= level_d;
      ovf_q   <= ovf_set  | (ovf_q  & ~bus.clr_err);
      perr_q  <= perr_set | (perr_q & ~bus.clr_err);
      ferr_q  <= ferr_set | (ferr_q & ~bus.clr_err);
    end
  end

  assign bus.data       = mem_q[rd_ptr_q];
  assign bus.ready      = ready;
  assign bus.level      = level_q;
  assign bus.overflow   = ovf_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames with hand-computed expected bytes,
// levels, flags and the stop-edge-to-ready latency.
module tb_ps2_rx_fifo;

  localparam int unsigned DL = 3;
  localparam int unsigned FL = 4;
  localparam int unsigned TO = 5000;

  logic clk = 1'b0;
  logic clrn = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  ps2_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  ps2_rx_fifo #(
    .DEPTH_LOG2 (DL),
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk     (clk),
    .clrn    (clrn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Data set 6 clk before the falling edge, clock low 12 clk, high 12 clk overall.
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (6) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (12) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b, input logic par_flip, input logic stop,
                       input int glitch_after, input logic chk_lat);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ps2_bit(bits[i]);
      if (i == glitch_after) glitch();
    end
    ps2_data = bits[10];
    repeat (6) @(negedge clk);
    ps2_clk = 1'b0;
    if (chk_lat) begin
      repeat (FL + 3) @(negedge clk);
      check("lat_not_yet", {31'd0, bus.ready}, 32'd0);
      @(negedge clk);
      check("lat_ready", {31'd0, bus.ready}, 32'd1);
      repeat (12 - FL - 4) @(negedge clk);
    end else begin
      repeat (12) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic pop();
    bus.nextdata_n = 1'b0;
    @(negedge clk);
    bus.nextdata_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_errs();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, bus.overflow, bus.parity_err, bus.frame_err}, {29'd0, exp});
  endtask

  initial begin
    bus.nextdata_n = 1'b1;
    bus.clr_err    = 1'b0;
    #2 clrn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_level", {28'd0, bus.level}, 32'd0);
    check_flags("rst_flags", 3'b000);
    clrn = 1'b1;
    repeat (4) @(negedge clk);

    // 1: good frame 0x1C with latency check
    frame(8'h1C, 1'b0, 1'b1, -1, 1'b1);
    check("t1_data", {24'd0, bus.data}, 32'h1C);
    check("t1_level", {28'd0, bus.level}, 32'd1);
    check_flags("t1_flags", 3'b000);
    pop();
    check("t1_empty", {31'd0, bus.ready}, 32'd0);

    // 2: bad parity, then clear
    frame(8'h1C, 1'b1, 1'b1, -1, 1'b0);
    check("t2_level", {28'd0, bus.level}, 32'd0);
    check_flags("t2_perr", 3'b010);
    clear_errs();
    check_flags("t2_cleared", 3'b000);

    // 3: overflow on the ninth byte, then drain in order
    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b1, -1, 1'b0);
    check("t3_level", {28'd0, bus.level}, 32'd8);
    check("t3_head", {24'd0, bus.data}, 32'h01);
    check_flags("t3_ovf", 3'b100);
    for (int i = 1; i <= 8; i++) begin
      check("t3_pop_data", {24'd0, bus.data}, 32'(i));
      pop();
    end
    check("t3_drained", {31'd0, bus.ready}, 32'd0);
    clear_errs();

    // 4: partial frame times out, next frame still decodes
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (1000) @(negedge clk);
    check_flags("t4_no_to_yet", 3'b000);
    repeat (TO) @(negedge clk);
    check_flags("t4_timeout", 3'b001);
    frame(8'hF0, 1'b0, 1'b1, -1, 1'b0);
    check("t4_level", {28'd0, bus.level}, 32'd1);
    check("t4_data", {24'd0, bus.data}, 32'hF0);
    check_flags("t4_flags", 3'b001);
    pop();
    clear_errs();

    // 5: short ps2_clk glitches idle (with data low) and mid-frame are ignored
    ps2_data = 1'b0;
    glitch();
    ps2_data = 1'b1;
    repeat (6) @(negedge clk);
    frame(8'h5A, 1'b0, 1'b1, 3, 1'b0);
    check("t5_level", {28'd0, bus.level}, 32'd1);
    check("t5_data", {24'd0, bus.data}, 32'h5A);
    check_flags("t5_flags", 3'b000);
    pop();

    // 6: async reset mid-frame clears level and flags, then recovery
    frame(8'h11, 1'b0, 1'b1, -1, 1'b0);
    frame(8'h22, 1'b0, 1'b1, -1, 1'b0);
    frame(8'h33, 1'b0, 1'b1, -1, 1'b0);
    frame(8'h44, 1'b1, 1'b1, -1, 1'b0);
    check("t6_level3", {28'd0, bus.level}, 32'd3);
    check_flags("t6_perr", 3'b010);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    clrn = 1'b0;
    #1;
    check("t6_rst_ready", {31'd0, bus.ready}, 32'd0);
    check("t6_rst_level", {28'd0, bus.level}, 32'd0);
    check_flags("t6_rst_flags", 3'b000);
    @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    frame(8'h77, 1'b0, 1'b1, -1, 1'b0);
    check("t6_level", {28'd0, bus.level}, 32'd1);
    check("t6_data", {24'd0, bus.data}, 32'h77);
    check_flags("t6_flags", 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
